// File: rtl/bit_serializer_pkg.sv
// Shared types and defaults for the bit serializer and its downstream detector bench.
// No logic; pure declarations.
// No flow control.
package bit_serializer_pkg;

    // Serializer control state.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default word width.
    localparam int unsigned DEF_WIDTH = 8;

    // Level placed on the serial line when nothing is being shifted.
    localparam logic DEF_IDLE_BIT = 1'b0;

    // Bit-counter width for a given word width (counter runs WIDTH-1 down to 0).
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector: one bit per clk, no gaps between words.
// Latency: first bit on ser_out the cycle after the accepting edge.
// Backpressure: one-entry hold register; in_ready low only while the hold register is occupied.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter bit          MSB_FIRST = 1'b1,
    parameter logic        IDLE_BIT  = DEF_IDLE_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_start,
    output logic             word_done,
    output logic             underrun
);

    localparam int unsigned      CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   sreg_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   hold_q;
    logic               hold_full_q;
    logic               underrun_q;

    logic               accept;
    logic               at_boundary;
    logic               stop;
    logic               head;
    logic [WIDTH-1:0]   shifted;

    // Ready depends only on the hold register, so the producer never sees a path from ser_* logic.
    assign in_ready    = !hold_full_q && !rst;
    assign accept      = in_valid && in_ready;
    assign at_boundary = (state_q == SHIFT) && (cnt_q == '0);
    // Last bit going out with nothing held and nothing offered: the stream breaks here.
    assign stop        = at_boundary && !hold_full_q && !accept;

    assign head    = MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0];
    assign shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], IDLE_BIT}
                               : {IDLE_BIT, sreg_q[WIDTH-1:1]};

    assign underrun = underrun_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave IDLE on an accept, fall back to IDLE only when the stream runs dry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (stop)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Shifter, bit counter, hold register and underrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q      <= {WIDTH{IDLE_BIT}};
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= stop;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sreg_q <= in_data;
                        cnt_q  <= CNT_LAST;
                    end
                end
                SHIFT: begin
                    if (cnt_q != '0) begin
                        sreg_q <= shifted;
                        cnt_q  <= cnt_q - CNT_ONE;
                        if (accept) begin
                            hold_q      <= in_data;
                            hold_full_q <= 1'b1;
                        end
                    end else if (hold_full_q) begin
                        // Word boundary: drain the held word with no gap.
                        sreg_q      <= hold_q;
                        hold_full_q <= 1'b0;
                        cnt_q       <= CNT_LAST;
                    end else if (accept) begin
                        // Word boundary with an empty hold: bypass straight into the shifter.
                        sreg_q <= in_data;
                        cnt_q  <= CNT_LAST;
                    end else begin
                        sreg_q <= {WIDTH{IDLE_BIT}};
                    end
                end
                default: begin
                    sreg_q <= {WIDTH{IDLE_BIT}};
                end
            endcase
        end
    end

    // Serial outputs come only from registered state.
    always_comb begin
        ser_out    = IDLE_BIT;
        ser_valid  = 1'b0;
        word_start = 1'b0;
        word_done  = 1'b0;
        if (state_q == SHIFT) begin
            ser_out    = head;
            ser_valid  = 1'b1;
            word_start = (cnt_q == CNT_LAST);
            word_done  = (cnt_q == '0);
        end
    end

endmodule
